// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with synchronous flush, global pause (rdy_in) and saturating stall counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer with registered in_ready; default is a single entry.
module pipe_stage_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy_in,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_cnt
);

    // State encoding is {skid_valid, main_valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] STALL_MAX = '1;
    localparam logic [CNT_W-1:0] STALL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
`ifdef PIPE_STAGE_SKID_EN
    logic [WIDTH-1:0] skid_q, skid_d;
`endif
    logic [CNT_W-1:0] stall_q, stall_d;

    logic             in_fire;
    logic             out_fire;
    logic             advance;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready & rdy_in;
    // Flush wins over every transfer; a paused stage ignores both.
    assign advance  = rdy_in & ~flush;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        if (rdy_in && flush) begin
            state_d = EMPTY;
        end else if (advance) begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) state_d = ONE;
                end
                ONE: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (in_fire && !out_fire) begin
                        state_d = FULL;
                    end else if (!in_fire && out_fire) begin
                        state_d = EMPTY;
                    end
`else
                    if (!in_fire && out_fire) state_d = EMPTY;
`endif
                end
                FULL: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (out_fire) state_d = ONE;
`else
                    state_d = EMPTY;
`endif
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        out_valid = (state_q != EMPTY);
        out_data  = main_q;
        stall_cnt = stall_q;
`ifdef PIPE_STAGE_SKID_EN
        in_ready  = rdy_in & (state_q != FULL);
`else
        // Single entry: a draining entry frees the slot in the same cycle,
        // which puts out_ready on the in_ready path.
        in_ready  = rdy_in & (~out_valid | out_ready);
`endif
    end

    // ------------------------------------------------------------------
    // Payload datapath
    // ------------------------------------------------------------------
    always_comb begin
        main_d = main_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_d = skid_q;
`endif
        if (advance) begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) main_d = in_data;
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end
`ifdef PIPE_STAGE_SKID_EN
                    else if (in_fire) begin
                        skid_d = in_data;
                    end
`endif
                end
                FULL: begin
`ifdef PIPE_STAGE_SKID_EN
                    if (out_fire) main_d = skid_q;
`endif
                end
                default: main_d = main_q;
            endcase
        end
    end

    // NOTE: the payload entries are plain registers, not a memory array, so
    // they take the async reset and out_data reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_q <= '0;
`endif
        end else begin
            main_q <= main_d;
`ifdef PIPE_STAGE_SKID_EN
            skid_q <= skid_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stall counter: saturating, frozen while paused, untouched by flush
    // ------------------------------------------------------------------
    always_comb begin
        stall_d = stall_q;
        if (rdy_in && out_valid && !out_ready && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + STALL_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg; inputs change on the falling edge, outputs checked 1 time unit later.
// Covers both builds: skid-specific steps sit under PIPE_STAGE_SKID_EN, single-entry steps otherwise.
module tb_pipe_stage_reg;

    localparam int W  = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdy_in;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [CW-1:0] stall_cnt;

    logic          s_in_valid;
    logic          s_in_ready;
    logic [7:0]    s_in_data;
    logic          s_out_valid;
    logic          s_out_ready;
    logic [7:0]    s_out_data;
    logic [3:0]    s_stall_cnt;

    int n_assert = 0;
    int n_fail   = 0;
    int exp_stall;

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy_in    (rdy_in),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .stall_cnt (stall_cnt)
    );

    pipe_stage_reg #(.WIDTH(8), .CNT_W(4)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .rdy_in    (1'b1),
        .flush     (1'b0),
        .in_valid  (s_in_valid),
        .in_ready  (s_in_ready),
        .in_data   (s_in_data),
        .out_valid (s_out_valid),
        .out_ready (s_out_ready),
        .out_data  (s_out_data),
        .stall_cnt (s_stall_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; rdy_in = 1'b1; flush = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data",  64'(out_data),  64'(0));
        chk("rst_stall",     64'(stall_cnt), 64'(0));
        chk("rst_in_ready",  64'(in_ready),  64'(1));
        @(negedge clk); rst = 1'b0;

        // Streaming 1..8 with out_ready held high
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_data = W'(i);
            @(negedge clk); #1;
            chk("stream_valid", 64'(out_valid), 64'(1));
            chk("stream_data",  64'(out_data),  64'(i));
            chk("stream_ready", 64'(in_ready),  64'(1));
        end
        in_valid = 1'b0;
        @(negedge clk); #1;
        chk("stream_drained", 64'(out_valid), 64'(0));
        chk("stream_stall",   64'(stall_cnt), 64'(0));

`ifdef PIPE_STAGE_SKID_EN
        // Back-pressure into the skid entry
        in_valid = 1'b1; in_data = 32'hA5; out_ready = 1'b0;
        @(negedge clk); #1;
        chk("bp_first_data", 64'(out_data), 64'hA5);
        chk("bp_one_ready",  64'(in_ready), 64'(1));
        in_data = 32'h5A;
        @(negedge clk); #1;
        chk("bp_full_ready", 64'(in_ready), 64'(0));
        chk("bp_full_data",  64'(out_data), 64'hA5);
        in_data = 32'hC3;
        repeat (2) @(negedge clk);
        #1;
        chk("bp_stall3",     64'(stall_cnt), 64'(3));
        chk("bp_held_ready", 64'(in_ready),  64'(0));
        chk("bp_held_data",  64'(out_data),  64'hA5);
        out_ready = 1'b1; #1;
        chk("bp_ready_registered", 64'(in_ready), 64'(0));
        @(negedge clk); #1;
        chk("bp_second_data", 64'(out_data), 64'h5A);
        chk("bp_reopen",      64'(in_ready), 64'(1));
        @(negedge clk); #1;
        chk("bp_third_data",  64'(out_data),  64'hC3);
        chk("bp_third_valid", 64'(out_valid), 64'(1));
        in_valid = 1'b0;
        @(negedge clk); #1;
        chk("bp_drained",     64'(out_valid), 64'(0));
        chk("bp_stall_final", 64'(stall_cnt), 64'(3));

        // Flush from FULL with a same-cycle offer
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hD1;
        @(negedge clk);
        in_data = 32'hD2;
        @(negedge clk); #1;
        chk("fl_full_ready", 64'(in_ready),  64'(0));
        chk("fl_pre_stall",  64'(stall_cnt), 64'(4));
        flush = 1'b1; in_data = 32'hEE; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_out_valid", 64'(out_valid), 64'(0));
        chk("fl_in_ready",  64'(in_ready),  64'(1));
        chk("fl_stall",     64'(stall_cnt), 64'(4));
        @(negedge clk); #1;
        chk("fl_no_ghost",  64'(out_valid), 64'(0));
        exp_stall = 4;
`else
        // Single entry: in_ready follows out_ready combinationally
        in_valid = 1'b1; in_data = 32'hA5; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("ns_data",       64'(out_data),  64'hA5);
        chk("ns_valid",      64'(out_valid), 64'(1));
        chk("ns_ready_low",  64'(in_ready),  64'(0));
        repeat (3) @(negedge clk);
        #1;
        chk("ns_stall3",     64'(stall_cnt), 64'(3));
        chk("ns_held_data",  64'(out_data),  64'hA5);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h5A; #1;
        chk("ns_ready_same_cycle", 64'(in_ready), 64'(1));
        @(negedge clk); #1;
        chk("ns_reload_data",  64'(out_data),  64'h5A);
        chk("ns_reload_valid", 64'(out_valid), 64'(1));

        // Flush beats a simultaneous reload
        flush = 1'b1; in_data = 32'hEE; #1;
        chk("fl_in_ready_pre", 64'(in_ready), 64'(1));
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_out_valid", 64'(out_valid), 64'(0));
        chk("fl_in_ready",  64'(in_ready),  64'(1));
        chk("fl_stall",     64'(stall_cnt), 64'(3));
        @(negedge clk); #1;
        chk("fl_no_ghost",  64'(out_valid), 64'(0));
        exp_stall = 3;
`endif

        // Pause: rdy_in low freezes everything, flush included
        in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0;
        @(negedge clk);
        rdy_in = 1'b0; flush = 1'b1; in_data = 32'h99; out_ready = 1'b1;
        #1;
        chk("pause_in_ready", 64'(in_ready), 64'(0));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk("pause_valid", 64'(out_valid), 64'(1));
            chk("pause_data",  64'(out_data),  64'h77);
            chk("pause_stall", 64'(stall_cnt), 64'(exp_stall));
            chk("pause_ready", 64'(in_ready),  64'(0));
        end
        rdy_in = 1'b1; flush = 1'b0;
        @(negedge clk); #1;
        chk("resume_data",  64'(out_data),  64'h99);
        chk("resume_valid", 64'(out_valid), 64'(1));
        in_valid = 1'b0;
        @(negedge clk); #1;
        chk("resume_drained", 64'(out_valid), 64'(0));

        // Reset asserted between edges while holding traffic
        in_valid = 1'b1; in_data = 32'h11; out_ready = 1'b0;
        @(negedge clk);
        in_data = 32'h22;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("mid_pre_stall", 64'(stall_cnt), 64'(exp_stall + 1));
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid",    64'(out_valid), 64'(0));
        chk("mid_rst_stall",    64'(stall_cnt), 64'(0));
        chk("mid_rst_data",     64'(out_data),  64'(0));
        chk("mid_rst_in_ready", 64'(in_ready),  64'(1));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_valid", 64'(out_valid), 64'(0));

        // Saturation on the 4-bit counter instance
        s_in_valid = 1'b1; s_in_data = 8'h3C; s_out_ready = 1'b0;
        @(negedge clk);
        s_in_valid = 1'b0;
        #1;
        chk("sat_data",  64'(s_out_data),  64'h3C);
        chk("sat_valid", 64'(s_out_valid), 64'(1));
        repeat (14) @(negedge clk);
        #1;
        chk("sat_14", 64'(s_stall_cnt), 64'(14));
        repeat (6) @(negedge clk);
        #1;
        chk("sat_15", 64'(s_stall_cnt), 64'(15));
        s_out_ready = 1'b1;
        @(negedge clk); #1;
        chk("sat_no_wrap", 64'(s_stall_cnt), 64'(15));
        chk("sat_drained", 64'(s_out_valid), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
